// File: rtl/score_pkg.sv
// score_pkg: glyph geometry, 3x5 digit glyph ROM (bit row*3+col, row 0 top, col 0 left) and renderer FSM states
package score_pkg;
    localparam int GLYPH_W = 3;
    localparam int GLYPH_H = 5;
    typedef enum logic [1:0] {IDLE, CONVERT, DRAW, DONE} state_t;
    function automatic logic [14:0] rom_bits(input logic [14:0] v);
        for (int i = 0; i < 15; i++) rom_bits[i] = v[14-i];
    endfunction
    localparam logic [14:0] GLYPH_ROM [10] = '{
        rom_bits(15'b111_101_101_101_111),
        rom_bits(15'b010_110_010_010_111),
        rom_bits(15'b111_001_111_100_111),
        rom_bits(15'b111_001_111_001_111),
        rom_bits(15'b101_101_111_001_001),
        rom_bits(15'b111_100_111_001_111),
        rom_bits(15'b111_100_111_101_111),
        rom_bits(15'b111_001_001_001_001),
        rom_bits(15'b111_101_111_101_111),
        rom_bits(15'b111_101_111_001_111)
    };
endpackage

// File: rtl/bin_to_bcd_iter.sv
// bin_to_bcd_iter: iterative double-dabble, start loads bin, done after SCORE_W shift-add-3 cycles, bcd digit i in [4i+3:4i]
module bin_to_bcd_iter #(
    parameter int SCORE_W = 7,
    parameter int DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);
    localparam int CW = $clog2(SCORE_W + 1);
    logic [SCORE_W-1:0] sr;
    logic [CW-1:0] cnt;
    logic [4*DIGITS-1:0] adj;
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            bcd <= '0;
            sr <= '0;
            cnt <= '0;
        end else if (start) begin
            bcd <= '0;
            sr <= bin;
            cnt <= CW'(SCORE_W);
        end else if (cnt != '0) begin
            {bcd, sr} <= {adj, sr} << 1;
            cnt <= cnt - 1'b1;
        end
    end
    assign done = cnt == '0;
endmodule

// File: rtl/score_renderer.sv
// score_renderer: latches a saturated score, converts it to BCD and plots it as scaled 3x5 glyphs on x/y/color/plot under the draw/finish_drawing handshake
module score_renderer
    import score_pkg::*;
#(
    parameter int         SCORE_W = 7,
    parameter int         DIGITS = 2,
    parameter int         SCALE = 1,
    parameter logic [7:0] X0 = 8'd4,
    parameter logic [6:0] Y0 = 7'd2,
    parameter logic [2:0] FG_COLOR = 3'b111,
    parameter logic [2:0] BG_COLOR = 3'b000,
    parameter bit         BLANK_LEADING = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               draw,
    input  logic [SCORE_W-1:0] score,
    output logic [7:0]         x,
    output logic [6:0]         y,
    output logic [2:0]         color,
    output logic               plot,
    output logic               finish_drawing
);
    localparam int SLOT_W = (GLYPH_W + 1) * SCALE;
    localparam int W = DIGITS * SLOT_W;
    localparam int H = GLYPH_H * SCALE;
    localparam int MAX = 10 ** DIGITS - 1;
    if (X0 + W - 1 > 159 || Y0 + H - 1 > 119 || DIGITS < 1 || DIGITS > 4 || SCALE < 1 || SCALE > 4) begin : g_bad_params
        $error("score_renderer: parameters out of range");
    end
    state_t state;
    logic [7:0] col;
    logic [6:0] row;
    logic [SCORE_W-1:0] sat;
    logic [4*DIGITS-1:0] bcd;
    logic done;
    int slot, dig, gc, gr;
    logic [3:0] val;
    logic blank;
    logic [2:0] pix;
    assign sat = int'(score) > MAX ? SCORE_W'(MAX) : score;
    bin_to_bcd_iter #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_bcd (
        .clock(clock),
        .reset(reset),
        .start(state == IDLE && draw),
        .bin(sat),
        .bcd(bcd),
        .done(done)
    );
    // slot 0 is the leftmost (most significant) digit; a digit is blanked when it and all above it are zero
    always_comb begin
        slot = int'(col) / SLOT_W;
        dig = DIGITS - 1 - slot;
        gc = (int'(col) % SLOT_W) / SCALE;
        gr = int'(row) / SCALE;
        val = bcd[4*dig +: 4];
        blank = BLANK_LEADING && dig != 0 && (bcd >> (4*dig)) == '0;
        pix = (gc == GLYPH_W || blank || !GLYPH_ROM[val][gr*GLYPH_W+gc]) ? BG_COLOR : FG_COLOR;
    end
    // col/row point at the next pixel to emit; row reaching H marks the frame as complete
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            x <= '0;
            y <= '0;
            color <= '0;
            plot <= 1'b0;
            finish_drawing <= 1'b0;
            col <= '0;
            row <= '0;
        end else if (!draw) begin
            state <= IDLE;
            plot <= 1'b0;
            finish_drawing <= 1'b0;
            col <= '0;
            row <= '0;
        end else begin
            case (state)
                IDLE: state <= CONVERT;
                DONE: state <= DONE;
                default:
                    if (row == 7'(H)) begin
                        state <= DONE;
                        plot <= 1'b0;
                        finish_drawing <= 1'b1;
                    end else if (state == DRAW || done) begin
                        state <= DRAW;
                        plot <= 1'b1;
                        x <= X0 + col;
                        y <= Y0 + row;
                        color <= pix;
                        col <= col == 8'(W - 1) ? '0 : col + 8'd1;
                        row <= col == 8'(W - 1) ? row + 7'd1 : row;
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_score_renderer.sv
// tb_score_renderer: directed checks of score_renderer in default, leading-blank and 2x scale configurations
module tb_score_renderer;
    import score_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] score = '0;
    logic draw_a = 1'b0, draw_b = 1'b0, draw_c = 1'b0;
    logic [7:0] x_a, x_b, x_c;
    logic [6:0] y_a, y_b, y_c;
    logic [2:0] c_a, c_b, c_c;
    logic p_a, p_b, p_c, f_a, f_b, f_c;
    logic [1:0] sel = '0;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;
    logic m_p, m_f;
    logic [3:0] frame [0:63][0:31];
    int n_cmp = 0, n_bad = 0;
    int cyc, npix, first, fin;
    always #5 clk = ~clk;
    score_renderer u_a (
        .clock(clk), .reset(rst), .draw(draw_a), .score(score),
        .x(x_a), .y(y_a), .color(c_a), .plot(p_a), .finish_drawing(f_a)
    );
    score_renderer #(.BLANK_LEADING(1'b1)) u_b (
        .clock(clk), .reset(rst), .draw(draw_b), .score(score),
        .x(x_b), .y(y_b), .color(c_b), .plot(p_b), .finish_drawing(f_b)
    );
    score_renderer #(.SCALE(2)) u_c (
        .clock(clk), .reset(rst), .draw(draw_c), .score(score),
        .x(x_c), .y(y_c), .color(c_c), .plot(p_c), .finish_drawing(f_c)
    );
    assign m_x = sel == 2'd0 ? x_a : sel == 2'd1 ? x_b : x_c;
    assign m_y = sel == 2'd0 ? y_a : sel == 2'd1 ? y_b : y_c;
    assign m_c = sel == 2'd0 ? c_a : sel == 2'd1 ? c_b : c_c;
    assign m_p = sel == 2'd0 ? p_a : sel == 2'd1 ? p_b : p_c;
    assign m_f = sel == 2'd0 ? f_a : sel == 2'd1 ? f_b : f_c;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic start_cap();
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 32; j++) frame[i][j] = 4'd0;
        cyc = 0;
        npix = 0;
        first = -1;
        fin = -1;
    endtask
    task automatic sample();
        @(negedge clk);
        cyc++;
        if (m_p) begin
            if (first < 0) first = cyc;
            npix++;
            if (m_x < 8'd64 && m_y < 7'd32) frame[m_x[5:0]][m_y[4:0]] = {1'b1, m_c};
        end
        if (m_f && fin < 0) fin = cyc;
    endtask
    task automatic run_until_fin(input int maxc);
        while (fin < 0 && cyc < maxc) sample();
    endtask
    function automatic logic [31:0] row_mask(input int yy, input int w);
        logic [31:0] m = '0;
        for (int i = 0; i < w; i++) m = {m[30:0], frame[4+i][yy] == 4'b1111};
        return m;
    endfunction
    function automatic int count_bad(input int w, input int h);
        int b = 0;
        for (int i = 0; i < w; i++)
            for (int j = 0; j < h; j++)
                if (frame[4+i][2+j] != 4'b1111 && frame[4+i][2+j] != 4'b1000) b++;
        return b;
    endfunction
    task automatic check_glyph(input string tag, input logic [39:0] exp);
        for (int r = 0; r < 5; r++)
            check($sformatf("%s_row%0d", tag, r), row_mask(2 + r, 8), {24'd0, exp[39-8*r -: 8]});
        check({tag, "_bad"}, count_bad(8, 5), 0);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        check("rst_plot", p_a, 0);
        check("rst_fin", f_a, 0);
        check("rst_x", x_a, 0);
        check("rst_y", y_a, 0);
        check("rst_color", c_a, 0);
        check("rst_state", u_a.state, IDLE);
        rst = 1'b0;
        @(negedge clk);
        sel = 2'd0;
        start_cap();
        score = 7'd42;
        draw_a = 1'b1;
        run_until_fin(100);
        check("s42_first", first, 9);
        check("s42_npix", npix, 40);
        check("s42_fin", fin, 49);
        check("s42_plot_at_fin", m_p, 0);
        check("s42_px_4_2", frame[4][2], 4'b1111);
        check("s42_px_5_2", frame[5][2], 4'b1000);
        check("s42_px_7_2", frame[7][2], 4'b1000);
        check_glyph("s42", 40'b10101110_10100010_11101110_00101000_00101110);
        sample();
        sample();
        check("s42_done_held", m_f, 1);
        check("s42_done_noplot", m_p, 0);
        draw_a = 1'b0;
        sample();
        check("s42_release_fin", m_f, 0);
        start_cap();
        score = 7'd123;
        draw_a = 1'b1;
        run_until_fin(100);
        check("s123_npix", npix, 40);
        check("s123_fin", fin, 49);
        check_glyph("s123", 40'b11101110_10101010_11101110_00100010_11101110);
        draw_a = 1'b0;
        sample();
        sel = 2'd1;
        start_cap();
        score = 7'd7;
        draw_b = 1'b1;
        run_until_fin(100);
        check("blank7_npix", npix, 40);
        check_glyph("blank7", 40'b00001110_00000010_00000010_00000010_00000010);
        draw_b = 1'b0;
        sample();
        sel = 2'd0;
        start_cap();
        draw_a = 1'b1;
        run_until_fin(100);
        check("s07_npix", npix, 40);
        check_glyph("s07", 40'b11101110_10100010_10100010_10100010_11100010);
        draw_a = 1'b0;
        sample();
        sel = 2'd2;
        start_cap();
        score = 7'd0;
        draw_c = 1'b1;
        run_until_fin(300);
        check("x2_first", first, 9);
        check("x2_npix", npix, 160);
        check("x2_fin", fin, 169);
        check("x2_px_4_2", frame[4][2], 4'b1111);
        check("x2_px_5_2", frame[5][2], 4'b1111);
        check("x2_px_4_3", frame[4][3], 4'b1111);
        check("x2_px_5_3", frame[5][3], 4'b1111);
        check("x2_px_6_4", frame[6][4], 4'b1000);
        check("x2_row_y2", row_mask(2, 16), 32'b1111110011111100);
        check("x2_row_y4", row_mask(4, 16), 32'b1100110011001100);
        check("x2_bad", count_bad(16, 10), 0);
        draw_c = 1'b0;
        sample();
        sel = 2'd0;
        start_cap();
        score = 7'd42;
        draw_a = 1'b1;
        while (npix < 15 && cyc < 100) sample();
        check("rst15_reached", npix, 15);
        rst = 1'b1;
        sample();
        check("rst15_plot", p_a, 0);
        check("rst15_fin", f_a, 0);
        check("rst15_x", x_a, 0);
        check("rst15_y", y_a, 0);
        check("rst15_color", c_a, 0);
        check("rst15_state", u_a.state, IDLE);
        rst = 1'b0;
        score = 7'd58;
        start_cap();
        run_until_fin(100);
        check("rst15_first", first, 9);
        check("rst15_npix", npix, 40);
        check_glyph("s58", 40'b11101110_10001010_11101110_00101010_11101110);
        draw_a = 1'b0;
        sample();
        start_cap();
        score = 7'd42;
        draw_a = 1'b1;
        while (npix < 5 && cyc < 100) sample();
        score = 7'd17;
        while (npix < 10 && cyc < 100) sample();
        check("abort_reached", npix, 10);
        draw_a = 1'b0;
        sample();
        check("abort_plot", m_p, 0);
        check("abort_fin", m_f, 0);
        repeat (3) sample();
        check("abort_no_fin", fin, -1);
        check("abort_row0_kept42", row_mask(2, 8), 32'b10101110);
        start_cap();
        draw_a = 1'b1;
        run_until_fin(100);
        check("s17_first", first, 9);
        check("s17_npix", npix, 40);
        check("s17_origin", frame[4][2], 4'b1000);
        check_glyph("s17", 40'b01001110_11000010_01000010_01000010_11100010);
        draw_a = 1'b0;
        sample();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/score_renderer.md
Name: score_renderer

Overview:
- Parametrised successor to the two-digit score drawer.
- Latches a binary score and converts it to N BCD digits with an iterative double-dabble.
- Rasterises the digits as scaled 3x5 glyphs, one pixel per clock, onto the shared pixel-plot bus (x/y/color/plot).
- Sits beside the sky and catcher drawers under the top-level draw sequencer, using the same draw/finish_drawing handshake.

Parameters:
- SCORE_W, 7, width of the binary score input.
- DIGITS, 2, number of decimal digits shown (1..4).
- SCALE, 1, pixel replication per glyph cell (1..4).
- X0, 8'd4, left x of the score box.
- Y0, 7'd2, top y of the score box.
- FG_COLOR, 3'b111, colour of set glyph cells.
- BG_COLOR, 3'b000, colour of clear cells, gap columns and blanked digits.
- BLANK_LEADING, 0, when 1, leading zero digits are drawn entirely in BG_COLOR; the least significant digit is never blanked.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- draw  in  1  level request from the sequencer; high = render score.
- score  in  SCORE_W  binary score, sampled only on the IDLE->CONVERT transition.
- x  out  8  pixel x.
- y  out  7  pixel y.
- color  out  3  pixel colour.
- plot  out  1  pixel write strobe; x/y/color valid while high.
- finish_drawing  out  1  high while in DONE.

Behaviour:
- Reset (sampled at posedge while reset=1):
  - state=IDLE.
  - x=0, y=0, color=0, plot=0, finish_drawing=0.
  - BCD and scan counters cleared.
  - Reset wins over every other event, including mid-CONVERT and mid-DRAW.
- FSM states: IDLE, CONVERT, DRAW, DONE.
- IDLE:
  - draw=1 at edge k: latch score, enter CONVERT.
  - If score > 10^DIGITS-1, latch the saturated value 10^DIGITS-1 instead (e.g. 99 for DIGITS=2).
- CONVERT:
  - Exactly SCORE_W cycles of shift-add-3.
  - Afterwards BCD digit i sits in bits [4i+3:4i]; i=0 is the least significant digit.
- DRAW:
  - First plot=1 in the cycle after edge k+SCORE_W+1.
  - Outputs are registered.
  - One pixel per cycle with no bubbles.
- Scan region:
  - Width W = DIGITS*4*SCALE, height H = 5*SCALE.
  - Total pixels N = W*H (40 for the defaults).
  - Order is row-major: y outer, x inner.
  - x = X0+col, y = Y0+row.
- Pixel mapping:
  - Digit slot d = col/(4*SCALE), with slot 0 the most significant digit.
  - Glyph column gc = (col mod 4*SCALE)/SCALE; glyph row gr = row/SCALE.
  - gc=3 is the gap column and is always BG_COLOR.
  - Otherwise color = FG_COLOR if glyph bit [gr*3+gc] of that digit is set, else BG_COLOR.
  - Blanked digits are entirely BG_COLOR.
- After pixel N:
  - Next cycle plot=0, finish_drawing=1, state=DONE.
- DONE:
  - Held while draw=1.
  - draw=0 -> IDLE next edge, finish_drawing=0.
- draw deasserted during CONVERT or DRAW:
  - Abort to IDLE next edge; plot=0, finish_drawing=0.
  - A later request restarts from a fresh score sample and pixel (X0,Y0).
- score changes after latching are ignored until the next IDLE exit.
- Bounds: X0+W-1 <= 159 and Y0+H-1 <= 119. Checked by an elaboration-time assertion; no runtime clipping.

Decomposition:
- Package score_pkg holds:
  - GLYPH_W=3, GLYPH_H=5.
  - The 10-entry 15-bit glyph ROM as constants, bit index row*3+col, row 0 top, col 0 left.
  - Digit 0 = 111_101_101_101_111 read row by row.
  - Digit 4 = rows 101, 101, 111, 001, 001.
  - The FSM state enumeration.
- One natural sub-module, bin_to_bcd_iter:
  - start/done handshake, parameters SCORE_W and DIGITS.
  - Iterative double-dabble, SCORE_W cycles.
- The scan counters and colour mux stay in score_renderer.

Test Plan:
- Score 42, defaults (X0=4, Y0=2), draw held high from cycle 0:
  - First plot at (4,2) colour 3'b111 (top-left of glyph 4) after 7 CONVERT cycles.
  - Pixel (5,2) is 3'b000; pixel (7,2) is the gap, 3'b000.
  - Exactly 40 plot cycles, then finish_drawing=1 and plot=0.
- Score 123, DIGITS=2:
  - Both digit slots render glyph 9 (saturation to 99).
  - finish_drawing after 40 pixels.
- Score 7, BLANK_LEADING=1:
  - All 20 tens-slot pixels are BG_COLOR.
  - Ones slot renders glyph 7.
  - Same score with BLANK_LEADING=0: tens slot shows glyph 0.
- SCALE=2, score 0:
  - 160 pixels.
  - Pixels (4,2),(5,2),(4,3),(5,3) are all FG, checking 2x2 replication.
  - finish_drawing at the expected cycle.
- Reset pulsed during pixel 15:
  - Next cycle all outputs are 0 and state is IDLE.
  - draw still high: new render starts with a fresh score sample and 40 full pixels.
- draw dropped during pixel 10, score changed 42->17 while drawing:
  - Immediate abort, no finish_drawing.
  - draw reasserted: renders 17 from (X0,Y0).
